// File: rtl/sign_mag_pkg.sv
// Shared types and helpers for the bit-serial sign-magnitude subtractor.
package sign_mag_pkg;

  typedef enum logic [1:0] {IDLE, CMP, ADD, DONE} state_t;

  localparam int unsigned DEFAULT_N = 4;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    x = 1;
    while (x < v) begin
      x = x << 1;
      r++;
    end
    return r;
  endfunction

  function automatic int unsigned sign_bit(input int unsigned n);
    return n - 1;
  endfunction

endpackage

// File: rtl/sm_bit_cell.sv
// One-bit full adder / subtractor; cout is carry when sub=0, borrow when sub=1.
module sm_bit_cell (
  input  logic x,
  input  logic y,
  input  logic cin,
  input  logic sub,
  output logic s,
  output logic cout
);

  always_comb begin
    s    = x ^ y ^ cin;
    cout = sub ? ((~x & y) | (~x & cin) | (y & cin))
               : ((x & y) | (x & cin) | (y & cin));
  end

endmodule

// File: rtl/sign_mag_serial_sub.sv
// Bit-serial sign-magnitude subtractor: diff = a - b, one magnitude bit per clock.
// Optional NEG_ZERO_NORM_EN forces a zero magnitude result to carry a positive sign.
module sign_mag_serial_sub
  import sign_mag_pkg::*;
#(
  parameter int unsigned N = DEFAULT_N
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] diff,
  output logic         overflow
);

  localparam int unsigned M        = N - 1;
  localparam int unsigned SIGN_BIT = sign_bit(N);
  localparam int unsigned IW       = (clog2(M) > 0) ? clog2(M) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(M - 1);

  state_t        state_q;
  logic [M-1:0]  mag_a_q, mag_b_q, mag_res_q;
  logic          sign_a_q, eff_sign_b_q;
  logic          a_ge_b_q, decided_q, carry_q;
  logic [IW-1:0] idx_q;

  logic          same_sign, op_x, op_y, bit_s, bit_cout, sign_next;
  logic [M-1:0]  mag_next;

  // Subtract case always takes max - min so the final borrow is zero.
  always_comb begin
    same_sign = (sign_a_q == eff_sign_b_q);
    op_x      = (same_sign || a_ge_b_q) ? mag_a_q[idx_q] : mag_b_q[idx_q];
    op_y      = (same_sign || a_ge_b_q) ? mag_b_q[idx_q] : mag_a_q[idx_q];
    mag_next  = (mag_res_q >> 1) | (M'(bit_s) << (M - 1));
    sign_next = a_ge_b_q ? sign_a_q : eff_sign_b_q;
`ifdef NEG_ZERO_NORM_EN
    if (mag_next == '0) sign_next = 1'b0;
`endif
  end

  sm_bit_cell u_cell (
    .x    (op_x),
    .y    (op_y),
    .cin  (carry_q),
    .sub  (~same_sign),
    .s    (bit_s),
    .cout (bit_cout)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
      diff         <= '0;
      overflow     <= 1'b0;
      mag_a_q      <= '0;
      mag_b_q      <= '0;
      mag_res_q    <= '0;
      sign_a_q     <= 1'b0;
      eff_sign_b_q <= 1'b0;
      a_ge_b_q     <= 1'b0;
      decided_q    <= 1'b0;
      carry_q      <= 1'b0;
      idx_q        <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid && in_ready) begin
            mag_a_q      <= a[M-1:0];
            mag_b_q      <= b[M-1:0];
            sign_a_q     <= a[SIGN_BIT];
            eff_sign_b_q <= ~b[SIGN_BIT];
            a_ge_b_q     <= 1'b1;
            decided_q    <= 1'b0;
            mag_res_q    <= '0;
            idx_q        <= LAST_IDX;
            in_ready     <= 1'b0;
            state_q      <= CMP;
          end
        end
        CMP: begin
          if (!decided_q && (mag_a_q[idx_q] != mag_b_q[idx_q])) begin
            a_ge_b_q  <= mag_a_q[idx_q];
            decided_q <= 1'b1;
          end
          if (idx_q == '0) begin
            carry_q <= 1'b0;
            state_q <= ADD;
          end else begin
            idx_q <= idx_q - 1'b1;
          end
        end
        ADD: begin
          mag_res_q <= mag_next;
          carry_q   <= bit_cout;
          if (idx_q == LAST_IDX) begin
            diff      <= {sign_next, mag_next};
            overflow  <= same_sign & bit_cout;
            out_valid <= 1'b1;
            state_q   <= DONE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sign_mag_serial_sub.sv
// Scoreboard bench for sign_mag_serial_sub (N=4); honours NEG_ZERO_NORM_EN when defined.
module tb_sign_mag_serial_sub;

  localparam int N = 4;

  typedef struct packed {
    logic [N-1:0] diff;
    logic         ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid, in_ready, out_valid, out_ready, overflow;
  logic [N-1:0] a, b, diff;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  sign_mag_serial_sub #(.N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .overflow  (overflow)
  );

  // Reference arithmetic on integers.
  function automatic exp_t model(input logic [N-1:0] ma, input logic [N-1:0] mb);
    int   va, vb, r;
    logic sa, sb, sr;
    exp_t e;
    sa = ma[N-1];
    sb = ~mb[N-1];
    va = int'(ma[N-2:0]);
    vb = int'(mb[N-2:0]);
    e.ovf = 1'b0;
    if (sa == sb) begin
      r  = va + vb;
      sr = sa;
      e.ovf = (r >= (1 << (N - 1)));
    end else if (va >= vb) begin
      r  = va - vb;
      sr = sa;
    end else begin
      r  = vb - va;
      sr = sb;
    end
    r = r % (1 << (N - 1));
`ifdef NEG_ZERO_NORM_EN
    if (r == 0) sr = 1'b0;
`endif
    e.diff = {sr, 3'(r)};
    return e;
  endfunction

  task automatic do_op(input logic [N-1:0] ta, input logic [N-1:0] tb_v, input exp_t e,
                       input bit chk_lat);
    int   k;
    exp_t exp_v;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL accept_ready: in_ready=%b expected 1", in_ready);
    end
    a = ta;
    b = tb_v;
    in_valid = 1'b1;
    sb_q.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_ready: in_ready=%b expected 0", in_ready);
    end
    k = 0;
    while (out_valid !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (k >= 40) begin
      n_fail++;
      $display("FAIL timeout: out_valid never rose for a=%b b=%b", ta, tb_v);
    end
    if (chk_lat) begin
      n_checks++;
      if (k != 2 * N - 2) begin
        n_fail++;
        $display("FAIL latency: got %0d cycles expected %0d", k, 2 * N - 2);
      end
    end
    if (sb_q.size() > 0) begin
      exp_v = sb_q.pop_front();
      n_checks++;
      if (diff !== exp_v.diff || overflow !== exp_v.ovf) begin
        n_fail++;
        $display("FAIL result a=%b b=%b: diff=%b ovf=%b expected diff=%b ovf=%b",
                 ta, tb_v, diff, overflow, exp_v.diff, exp_v.ovf);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a = '0;
    b = '0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || diff !== 4'b0000 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values: in_ready=%b out_valid=%b diff=%b ovf=%b expected 1 0 0000 0",
               in_ready, out_valid, diff, overflow);
    end
    reset = 1'b0;
  endtask

  task automatic test_plan_vectors();
    exp_t e;
    e.diff = 4'b0001; e.ovf = 1'b0;
    do_op(4'b0011, 4'b0010, e, 1'b1);
    e.diff = 4'b0000; e.ovf = 1'b1;
    do_op(4'b0101, 4'b1011, e, 1'b1);
    e.diff = 4'b1100; e.ovf = 1'b0;
    do_op(4'b0010, 4'b0110, e, 1'b0);
`ifdef NEG_ZERO_NORM_EN
    e.diff = 4'b0000; e.ovf = 1'b0;
`else
    e.diff = 4'b1000; e.ovf = 1'b0;
`endif
    do_op(4'b1011, 4'b1011, e, 1'b0);
  endtask

  task automatic test_backpressure();
    int   k;
    exp_t e;
    e.diff = 4'b1100; e.ovf = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    a = 4'b0010;
    b = 4'b0110;
    in_valid = 1'b1;
    sb_q.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    k = 0;
    while (out_valid !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (k >= 40) begin
      n_fail++;
      $display("FAIL bp_timeout: out_valid never rose");
    end
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      a = 4'($urandom);
      b = 4'($urandom);
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || diff !== e.diff || overflow !== e.ovf) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: valid=%b ready=%b diff=%b ovf=%b expected 1 0 %b %b",
                 i, out_valid, in_ready, diff, overflow, e.diff, e.ovf);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    e = sb_q.pop_front();
    n_checks++;
    if (diff !== e.diff || overflow !== e.ovf) begin
      n_fail++;
      $display("FAIL bp_result: diff=%b ovf=%b expected %b %b", diff, overflow, e.diff, e.ovf);
    end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b expected 0 1", out_valid, in_ready);
    end
    do_op(4'b0110, 4'b0001, model(4'b0110, 4'b0001), 1'b1);
  endtask

  task automatic test_reset_mid_add();
    exp_t e;
    @(negedge clk);
    a = 4'b0111;
    b = 4'b1111;
    in_valid = 1'b1;
    sb_q.push_back(model(4'b0111, 4'b1111));
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    #1;
    void'(sb_q.pop_front());
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || diff !== 4'b0000 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_reset: in_ready=%b out_valid=%b diff=%b ovf=%b expected 1 0 0000 0",
               in_ready, out_valid, diff, overflow);
    end
    @(negedge clk);
    reset = 1'b0;
    e.diff = 4'b1010; e.ovf = 1'b0;
    do_op(4'b1001, 4'b0001, e, 1'b1);
  endtask

  task automatic test_random();
    logic [N-1:0] ra, rb;
    for (int i = 0; i < 24; i++) begin
      ra = 4'($urandom);
      rb = 4'($urandom);
      do_op(ra, rb, model(ra, rb), 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_plan_vectors();
    test_backpressure();
    test_reset_mid_add();
    test_random();
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
